// File: rtl/perf_cnt_if.sv
// Bus/CPU-side signal bundle for perf_cnt_bank: event strobes, control
// command port, valid/ready read request/response and live overflow flags.
interface perf_cnt_if #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 5
);
  logic [NUM_CH-1:0] evt;
  logic              ctrl_valid;
  logic              ctrl_ready;
  logic [1:0]        ctrl_op;
  logic [NUM_CH-1:0] ctrl_mask;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [CH_W-1:0]   rd_ch;
  logic [1:0]        rd_sel;
  logic              rd_resp_valid;
  logic              rd_resp_ready;
  logic [31:0]       rd_data;
  logic [NUM_CH-1:0] ovf;

  modport master (
    output evt, ctrl_valid, ctrl_op, ctrl_mask, rd_req_valid, rd_ch, rd_sel, rd_resp_ready,
    input  ctrl_ready, rd_req_ready, rd_resp_valid, rd_data, ovf
  );

  modport slave (
    input  evt, ctrl_valid, ctrl_op, ctrl_mask, rd_req_valid, rd_ch, rd_sel, rd_resp_ready,
    output ctrl_ready, rd_req_ready, rd_resp_valid, rd_data, ovf
  );
endinterface

// File: rtl/perf_cnt_bank.sv
// Bank of NUM_CH split low/high event counters with sticky overflow, per-channel
// freeze/clear, an all-channel snapshot and a two-state valid/ready read port.
module perf_cnt_bank #(
  parameter int          NUM_CH = 8,
  parameter logic [31:0] LO_MAX = 32'd999999999,
  parameter int          CH_W   = 5
) (
  input logic      clk,
  input logic      rst,
  perf_cnt_if.slave bus
);

  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_FRZ  = 2'b10;
  localparam logic [1:0] OP_SNAP = 2'b11;

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0][31:0] lo_q, lo_d, hi_q, hi_d;
  logic [NUM_CH-1:0][31:0] slo_q, slo_d, shi_q, shi_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d, frz_q, frz_d;
  logic [31:0]             rd_data_q, rd_data_d;

  logic        ctrl_rdy, rd_req_rdy, rd_resp_vld;
  logic        ctrl_acc, rd_acc;
  logic [31:0] rd_word;

  // Read FSM; a pending control command blocks read acceptance in IDLE
  always_comb begin
    state_d     = state_q;
    ctrl_rdy    = 1'b0;
    rd_req_rdy  = 1'b0;
    rd_resp_vld = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ctrl_rdy   = 1'b1;
        rd_req_rdy = ~bus.ctrl_valid;
        if (bus.rd_req_valid && rd_req_rdy) state_d = ST_RESP;
      end
      ST_RESP: begin
        rd_resp_vld = 1'b1;
        if (bus.rd_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ctrl_acc = bus.ctrl_valid & ctrl_rdy;
  assign rd_acc   = bus.rd_req_valid & rd_req_rdy;

  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    ovf_d = ovf_q;
    frz_d = frz_q;
    slo_d = slo_q;
    shi_d = shi_q;
    for (int c = 0; c < NUM_CH; c++) begin
      // Clear beats a same-cycle event; freeze only gates from the next cycle
      if (ctrl_acc && bus.ctrl_op == OP_CLR && bus.ctrl_mask[c]) begin
        lo_d[c]  = '0;
        hi_d[c]  = '0;
        ovf_d[c] = 1'b0;
      end else if (bus.evt[c] && !frz_q[c]) begin
        if (lo_q[c] == LO_MAX) begin
          lo_d[c] = '0;
          hi_d[c] = hi_q[c] + 32'd1;
          if (hi_q[c] == 32'hFFFF_FFFF) ovf_d[c] = 1'b1;
        end else begin
          lo_d[c] = lo_q[c] + 32'd1;
        end
      end
      if (ctrl_acc && bus.ctrl_op == OP_FRZ  && bus.ctrl_mask[c]) frz_d[c] = 1'b1;
      if (ctrl_acc && bus.ctrl_op == OP_SNAP && bus.ctrl_mask[c]) frz_d[c] = 1'b0;
    end
    if (ctrl_acc && bus.ctrl_op == OP_SNAP) begin
      slo_d = lo_q;
      shi_d = hi_q;
    end
  end

  always_comb begin
    rd_word = '0;
    unique case (bus.rd_sel)
      2'b00: for (int c = 0; c < NUM_CH; c++) if (bus.rd_ch == CH_W'(c)) rd_word = slo_q[c];
      2'b01: for (int c = 0; c < NUM_CH; c++) if (bus.rd_ch == CH_W'(c)) rd_word = shi_q[c];
      2'b10: rd_word = 32'(ovf_q);
      default: rd_word = 32'(frz_q);
    endcase
    rd_data_d = rd_acc ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      slo_q     <= '0;
      shi_q     <= '0;
      ovf_q     <= '0;
      frz_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      slo_q     <= slo_d;
      shi_q     <= shi_d;
      ovf_q     <= ovf_d;
      frz_q     <= frz_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.ctrl_ready    = ctrl_rdy;
  assign bus.rd_req_ready  = rd_req_rdy;
  assign bus.rd_resp_valid = rd_resp_vld;
  assign bus.rd_data       = rd_data_q;
  assign bus.ovf           = ovf_q;

endmodule

// File: tb/tb_perf_cnt_bank.sv
// Directed bench for perf_cnt_bank with LO_MAX=9 so wraps are reachable.
module tb_perf_cnt_bank;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] d;

  perf_cnt_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

  perf_cnt_bank #(.NUM_CH(NUM_CH), .LO_MAX(32'd9), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ctrl(input logic [1:0] op, input logic [NUM_CH-1:0] mask);
    bus.ctrl_valid = 1'b1;
    bus.ctrl_op    = op;
    bus.ctrl_mask  = mask;
    tick();
    bus.ctrl_valid = 1'b0;
  endtask

  task automatic rd(input logic [CH_W-1:0] ch, input logic [1:0] sel, output logic [31:0] data);
    bus.rd_ch        = ch;
    bus.rd_sel       = sel;
    bus.rd_req_valid = 1'b1;
    tick();
    bus.rd_req_valid  = 1'b0;
    bus.rd_resp_ready = 1'b1;
    chk("rd_resp_valid", {31'b0, bus.rd_resp_valid}, 32'd1);
    data = bus.rd_data;
    tick();
    bus.rd_resp_ready = 1'b0;
  endtask

  task automatic events(input logic [NUM_CH-1:0] m, input int n);
    bus.evt = m;
    for (int i = 0; i < n; i++) tick();
    bus.evt = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.evt           = '0;
    bus.ctrl_valid    = 1'b0;
    bus.ctrl_op       = 2'b00;
    bus.ctrl_mask     = '0;
    bus.rd_req_valid  = 1'b0;
    bus.rd_ch         = '0;
    bus.rd_sel        = 2'b00;
    bus.rd_resp_ready = 1'b0;
    #12 rst = 1'b0;
    #1;
    chk("rst_ctrl_ready",    {31'b0, bus.ctrl_ready},    32'd1);
    chk("rst_rd_req_ready",  {31'b0, bus.rd_req_ready},  32'd1);
    chk("rst_rd_resp_valid", {31'b0, bus.rd_resp_valid}, 32'd0);
    chk("rst_rd_data",       bus.rd_data,                32'd0);
    chk("rst_ovf",           32'(bus.ovf),               32'd0);
    tick();

    // Overflow on ch1 from a preloaded terminal state
    force dut.hi_q = {{6{32'h0}}, 32'hFFFF_FFFF, 32'h0};
    force dut.lo_q = {{6{32'h0}}, 32'd9, 32'h0};
    #1;
    release dut.hi_q;
    release dut.lo_q;
    events(8'h02, 1);
    chk("ovf_lo1",  dut.lo_q[1],  32'd0);
    chk("ovf_hi1",  dut.hi_q[1],  32'd0);
    chk("ovf_flag", 32'(bus.ovf), 32'h2);
    rd(4'd0, 2'b10, d);
    chk("ovf_read", d, 32'h2);
    ctrl(2'b01, 8'h02);
    chk("ovf_cleared", 32'(bus.ovf), 32'd0);

    // Count and wrap: 23 events on ch0 -> lo=3, hi=2
    events(8'h01, 23);
    ctrl(2'b11, 8'h00);
    rd(4'd0, 2'b00, d);
    chk("wrap_slo0", d, 32'd3);
    rd(4'd0, 2'b01, d);
    chk("wrap_shi0", d, 32'd2);

    // Freeze ch2 with a same-cycle event, then 5 ignored events
    bus.evt = 8'h04;
    ctrl(2'b10, 8'h04);
    tick(); tick(); tick(); tick(); tick();
    bus.evt = '0;
    chk("frz_lo2", dut.lo_q[2], 32'd1);
    rd(4'd0, 2'b11, d);
    chk("frz_vec", d, 32'h4);

    // Clear ch3 with a same-cycle event
    events(8'h08, 3);
    chk("pre_clr_lo3", dut.lo_q[3], 32'd3);
    bus.evt = 8'h08;
    ctrl(2'b01, 8'h08);
    bus.evt = '0;
    chk("clr_lo3", dut.lo_q[3], 32'd0);

    ctrl(2'b11, 8'h04);
    rd(4'd0, 2'b11, d);
    chk("unfrz_vec", d, 32'h0);

    // Snapshot isolation: snapshot taken while lo0 reads 4, then 10 more events
    ctrl(2'b01, 8'h01);
    bus.evt = 8'h01;
    tick(); tick(); tick(); tick();
    ctrl(2'b11, 8'h00);
    for (int i = 0; i < 10; i++) tick();
    bus.evt = '0;
    chk("live_lo0", dut.lo_q[0], 32'd5);
    chk("live_hi0", dut.hi_q[0], 32'd1);
    rd(4'd0, 2'b00, d);
    chk("snap_slo0", d, 32'd4);

    // Response held under back-pressure
    bus.rd_ch        = 4'd0;
    bus.rd_sel       = 2'b00;
    bus.rd_req_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("hold_resp_valid",   {31'b0, bus.rd_resp_valid}, 32'd1);
      chk("hold_rd_data",      bus.rd_data,                32'd4);
      chk("hold_rd_req_ready", {31'b0, bus.rd_req_ready},  32'd0);
      chk("hold_ctrl_ready",   {31'b0, bus.ctrl_ready},    32'd0);
      tick();
    end
    bus.rd_req_valid  = 1'b0;
    bus.rd_resp_ready = 1'b1;
    tick();
    bus.rd_resp_ready = 1'b0;
    chk("resp_done", {31'b0, bus.rd_resp_valid}, 32'd0);

    // Control beats a simultaneous read request
    bus.ctrl_valid   = 1'b1;
    bus.ctrl_op      = 2'b00;
    bus.ctrl_mask    = '0;
    bus.rd_req_valid = 1'b1;
    #1;
    chk("prio_rd_req_ready", {31'b0, bus.rd_req_ready}, 32'd0);
    chk("prio_ctrl_ready",   {31'b0, bus.ctrl_ready},   32'd1);
    tick();
    bus.ctrl_valid   = 1'b0;
    bus.rd_req_valid = 1'b0;
    chk("prio_no_resp", {31'b0, bus.rd_resp_valid}, 32'd0);

    // Out-of-range channel index
    rd(4'd8, 2'b00, d);
    chk("oor_read", d, 32'd0);

    // Asynchronous reset while a response is pending
    bus.rd_ch        = 4'd0;
    bus.rd_sel       = 2'b00;
    bus.rd_req_valid = 1'b1;
    tick();
    bus.rd_req_valid = 1'b0;
    chk("pre_rst_resp_valid", {31'b0, bus.rd_resp_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_resp_dropped", {31'b0, bus.rd_resp_valid}, 32'd0);
    chk("rst_lo0",          dut.lo_q[0],                32'd0);
    chk("rst_hi0",          dut.hi_q[0],                32'd0);
    chk("rst_rd_data2",     bus.rd_data,                32'd0);
    chk("rst_ctrl_ready2",  {31'b0, bus.ctrl_ready},    32'd1);
    #3 rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
